// File: rtl/freq_cnt_pkg.sv
// Shared register map, bit positions, FSM state type and byte-strobe helper
// for the AXI4-Lite frequency counter.
package freq_cnt_pkg;

    // Register select values, taken from byte address bits [3:2]
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_GATE   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_START = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_IE    = 2;

    localparam int ST_BUSY = 0;
    localparam int ST_DONE = 1;
    localparam int ST_OVF  = 2;
    localparam int ST_GERR = 3;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } fc_state_t;

    // Merge the enabled bytes of new_val into cur
    function automatic logic [31:0] apply_wstrb(input logic [31:0] cur,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = cur;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/freq_cnt_sync.sv
// Two-flop synchroniser for the asynchronous measured signal, followed by a
// rising-edge detector that yields a one-cycle pulse per input edge.
module freq_cnt_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic meta;
    logic stable;
    logic stable_d;

    // NOTE: clocked state uses <= so every flop samples the pre-edge value of its neighbour.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta     <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
        end else begin
            meta     <= async_in;
            stable   <= meta;
            stable_d <= stable;
        end
    end

    assign rise = stable & ~stable_d;

endmodule

// File: rtl/freq_cnt_axil_slave.sv
// AXI4-Lite slave with CTRL/GATE/COUNT/STATUS registers driving a gated edge counter.
// Optional feature macro: FREQ_CNT_IRQ_EN (adds the irq output and CTRL.IE).
module freq_cnt_axil_slave
    import freq_cnt_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int CNT_W              = 32
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_areset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    input  logic                              f_in
`ifdef FREQ_CNT_IRQ_EN
    ,
    output logic                              irq
`endif
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic clk;
    logic rst;
    assign clk = s00_axi_aclk;
    assign rst = s00_axi_areset;

    // Write channel buffers
    logic          aw_full;
    logic [1:0]    aw_idx;
    logic          w_full;
    logic [DW-1:0] w_data;
    logic [3:0]    w_strb;
    logic          bvalid;

    // Read channel
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic [DW-1:0] rd_mux;

    // Register file
    logic          ctrl_cont;
    logic          ie_bit;
    logic [DW-1:0] gate_reg;
    logic [DW-1:0] count_reg;
    logic          st_done;
    logic          st_ovf;
    logic          st_gerr;
    logic          st_busy;

    // Measurement datapath
    fc_state_t     state;
    fc_state_t     state_next;
    logic [DW-1:0] gate_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic [DW-1:0] cnt_ext;
    logic          edge_pulse;

    logic wr_en;
    logic wr_ctrl;
    logic wr_gate;
    logic wr_status;
    logic start_req;
    logic gerr_set;
    logic ovf_set;
    logic load_gate;

    // Address LSBs and protection bits carry no meaning for this register block
    logic unused_ok;
    assign unused_ok = ^{s00_axi_awaddr[1:0], s00_axi_araddr[1:0],
                         s00_axi_awprot, s00_axi_arprot};

    freq_cnt_sync u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (f_in),
        .rise     (edge_pulse)
    );

    // ---------------------------------------------------------------- write
    assign s00_axi_awready = ~rst & ~aw_full & ~bvalid;
    assign s00_axi_wready  = ~rst & ~w_full  & ~bvalid;
    assign s00_axi_bvalid  = bvalid;
    assign s00_axi_bresp   = 2'b00;

    assign wr_en     = aw_full & w_full & ~bvalid;
    assign wr_ctrl   = wr_en && (aw_idx == REG_CTRL);
    assign wr_gate   = wr_en && (aw_idx == REG_GATE);
    assign wr_status = wr_en && (aw_idx == REG_STATUS) && w_strb[0];
    assign start_req = wr_ctrl && w_strb[0] && w_data[CTRL_START];

    always_ff @(posedge clk) begin
        if (rst) begin
            aw_full <= 1'b0;
            aw_idx  <= '0;
            w_full  <= 1'b0;
            w_data  <= '0;
            w_strb  <= '0;
            bvalid  <= 1'b0;
        end else begin
            if (s00_axi_awvalid && s00_axi_awready) begin
                aw_full <= 1'b1;
                aw_idx  <= s00_axi_awaddr[3:2];
            end
            if (s00_axi_wvalid && s00_axi_wready) begin
                w_full <= 1'b1;
                w_data <= s00_axi_wdata;
                w_strb <= s00_axi_wstrb;
            end
            if (wr_en) begin
                bvalid <= 1'b1;
            end else if (bvalid && s00_axi_bready) begin
                bvalid  <= 1'b0;
                aw_full <= 1'b0;
                w_full  <= 1'b0;
            end
        end
    end

    // ----------------------------------------------------------------- read
    assign s00_axi_arready = ~rst & ~rvalid;
    assign s00_axi_rvalid  = rvalid;
    assign s00_axi_rdata   = rdata;
    assign s00_axi_rresp   = 2'b00;

    assign st_busy = (state != IDLE);

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        rd_mux = '0;
        case (s00_axi_araddr[3:2])
            REG_CTRL: begin
                rd_mux[CTRL_CONT] = ctrl_cont;
                rd_mux[CTRL_IE]   = ie_bit;
            end
            REG_GATE:  rd_mux = gate_reg;
            REG_COUNT: rd_mux = count_reg;
            REG_STATUS: begin
                rd_mux[ST_BUSY] = st_busy;
                rd_mux[ST_DONE] = st_done;
                rd_mux[ST_OVF]  = st_ovf;
                rd_mux[ST_GERR] = st_gerr;
            end
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else if (s00_axi_arvalid && s00_axi_arready) begin
            rvalid <= 1'b1;
            rdata  <= rd_mux;
        end else if (rvalid && s00_axi_rready) begin
            rvalid <= 1'b0;
        end
    end

    // ------------------------------------------------------------ registers
    assign gerr_set = (state == IDLE) && start_req && (gate_reg == '0);
    assign ovf_set  = (state == COUNT) && edge_pulse && (edge_cnt == CNT_MAX);

    always_comb begin
        cnt_ext = '0;
        cnt_ext[CNT_W-1:0] = edge_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_cont <= 1'b0;
            gate_reg  <= '0;
            count_reg <= '0;
            st_done   <= 1'b0;
            st_ovf    <= 1'b0;
            st_gerr   <= 1'b0;
        end else begin
            if (wr_ctrl && w_strb[0]) ctrl_cont <= w_data[CTRL_CONT];
            if (wr_gate) gate_reg <= apply_wstrb(gate_reg, w_data, w_strb);
            if (wr_status) begin
                if (w_data[ST_DONE]) st_done <= 1'b0;
                if (w_data[ST_OVF])  st_ovf  <= 1'b0;
                if (w_data[ST_GERR]) st_gerr <= 1'b0;
            end
            // Hardware sets come after the W1C clears so a same-cycle set wins
            if (gerr_set) st_gerr <= 1'b1;
            if (ovf_set)  st_ovf  <= 1'b1;
            if (state == DONE) begin
                st_done   <= 1'b1;
                count_reg <= cnt_ext;
            end
        end
    end

`ifdef FREQ_CNT_IRQ_EN
    logic ctrl_ie;

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_ie <= 1'b0;
            irq     <= 1'b0;
        end else begin
            if (wr_ctrl && w_strb[0]) ctrl_ie <= w_data[CTRL_IE];
            irq <= ctrl_ie & st_done;
        end
    end

    assign ie_bit = ctrl_ie;
`else
    assign ie_bit = 1'b0;
`endif

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_req && (gate_reg != '0)) state_next = COUNT;
            COUNT:   if (gate_cnt == DW'(1)) state_next = DONE;
            DONE:    state_next = ctrl_cont ? COUNT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // GATE is sampled only when a window opens, so later GATE writes wait for the next one
    assign load_gate = (state_next == COUNT) && (state != COUNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
        end else if (load_gate) begin
            gate_cnt <= gate_reg;
            edge_cnt <= '0;
        end else if (state == COUNT) begin
            gate_cnt <= gate_cnt - DW'(1);
            if (edge_pulse && (edge_cnt != CNT_MAX)) edge_cnt <= edge_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_freq_cnt_axil_slave.sv
// Self-checking bench for freq_cnt_axil_slave (CNT_W=4); read expectations are
// queued when a read is issued and compared by a monitor when R completes.
`timescale 1ns/1ps
module tb_freq_cnt_axil_slave;

    localparam logic [3:0] A_CTRL   = 4'h0;
    localparam logic [3:0] A_GATE   = 4'h4;
    localparam logic [3:0] A_COUNT  = 4'h8;
    localparam logic [3:0] A_STATUS = 4'hC;
`ifdef FREQ_CNT_IRQ_EN
    localparam logic [31:0] IE_RB = 32'h4;
`else
    localparam logic [31:0] IE_RB = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        areset;
    logic [3:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        f_in;
`ifdef FREQ_CNT_IRQ_EN
    logic        irq;
`endif

    always #5 clk = ~clk;

    freq_cnt_axil_slave #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4),
        .CNT_W              (4)
    ) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_areset  (areset),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .f_in            (f_in)
`ifdef FREQ_CNT_IRQ_EN
        ,
        .irq             (irq)
`endif
    );

    // Measured signal: half period in ns (multiple of 5), phase kept off the rising clock edge
    int f_half = 0;
    always begin
        if (f_half > 0) begin
            f_in = 1'b1;
            #(f_half);
            f_in = 1'b0;
            #(f_half);
        end else begin
            f_in = 1'b0;
            @(negedge clk);
            #2;
        end
    end

    int n_total = 0;
    int n_bad   = 0;
    int b_count = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] val;
        logic [31:0] mask;
        logic [31:0] tol;
    } rd_exp_t;

    rd_exp_t rd_q[$];
    string   tag_q[$];
    rd_exp_t mon_e;
    string   mon_tag;

    // Response monitor: sampled on the falling edge, the cycle before the handshake edge
    always @(negedge clk) begin
        if (!areset) begin
            if (bvalid && bready) begin
                b_count++;
                check("bresp", 32'(bresp), 32'h0);
            end
            if (rvalid && rready) begin
                check("rresp", 32'(rresp), 32'h0);
                if (rd_q.size() == 0) begin
                    check("r_unexpected", 32'h1, 32'h0);
                end else begin
                    mon_e   = rd_q.pop_front();
                    mon_tag = tag_q.pop_front();
                    if (mon_e.tol == 0)
                        check(mon_tag, rdata & mon_e.mask, mon_e.val & mon_e.mask);
                    else
                        check($sformatf("%s(got %0d want %0d+-%0d)", mon_tag, rdata, mon_e.val, mon_e.tol),
                              32'((rdata + mon_e.tol >= mon_e.val) && (rdata <= mon_e.val + mon_e.tol)),
                              32'h1);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int aw_dly, input int w_dly);
        bit aw_ok = 1'b0;
        bit w_ok  = 1'b0;
        bit b_ok  = 1'b0;
        fork
            begin
                repeat (aw_dly) @(posedge clk);
                #1;
                awaddr  = addr;
                awvalid = 1'b1;
                for (int i = 0; i < 200; i++) begin
                    @(negedge clk);
                    if (awready) begin aw_ok = 1'b1; break; end
                end
                @(posedge clk);
                #1;
                awvalid = 1'b0;
            end
            begin
                repeat (w_dly) @(posedge clk);
                #1;
                wdata  = data;
                wstrb  = strb;
                wvalid = 1'b1;
                for (int i = 0; i < 200; i++) begin
                    @(negedge clk);
                    if (wready) begin w_ok = 1'b1; break; end
                end
                @(posedge clk);
                #1;
                wvalid = 1'b0;
            end
        join
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bvalid) begin b_ok = 1'b1; break; end
        end
        @(posedge clk);
        #1;
        if (!aw_ok) check("aw_timeout", 32'h0, 32'h1);
        if (!w_ok)  check("w_timeout",  32'h0, 32'h1);
        if (!b_ok)  check("b_timeout",  32'h0, 32'h1);
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] data);
        axi_write(addr, data, 4'hF, 0, 0);
    endtask

    task automatic axi_read(input logic [3:0] addr, input string tag, input logic [31:0] val,
                            input logic [31:0] mask, input logic [31:0] tol, input int hold);
        rd_exp_t e;
        bit ok = 1'b0;
        e.val  = val;
        e.mask = mask;
        e.tol  = tol;
        rd_q.push_back(e);
        tag_q.push_back(tag);
        rready  = (hold == 0);
        araddr  = addr;
        arvalid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (arready) begin ok = 1'b1; break; end
        end
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        if (!ok) check({tag, "_ar_timeout"}, 32'h0, 32'h1);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (rvalid) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            check({tag, "_r_timeout"}, 32'h0, 32'h1);
            void'(rd_q.pop_back());
            void'(tag_q.pop_back());
        end else if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check({tag, "_hold_valid"}, 32'(rvalid), 32'h1);
                check({tag, "_hold_data"}, rdata & mask, val & mask);
            end
            @(posedge clk);
            #1;
            rready = 1'b1;
        end
        @(posedge clk);
        #1;
        rready = 1'b1;
    endtask

    task automatic rd(input logic [3:0] addr, input string tag, input logic [31:0] val);
        axi_read(addr, tag, val, 32'hFFFF_FFFF, 32'h0, 0);
    endtask

    task automatic rd_m(input logic [3:0] addr, input string tag, input logic [31:0] val,
                        input logic [31:0] mask);
        axi_read(addr, tag, val, mask, 32'h0, 0);
    endtask

    initial begin
        #1ms;
        n_bad++;
        $display("FAIL watchdog: simulation did not finish in 1 ms");
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog expired");
    end

    int bc;

    initial begin
        areset  = 1'b1;
        awaddr  = '0;
        awprot  = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wvalid  = 1'b0;
        bready  = 1'b1;
        araddr  = '0;
        arprot  = '0;
        arvalid = 1'b0;
        rready  = 1'b1;

        // 1. reset
        repeat (3) begin
            @(negedge clk);
            check("rst_bvalid",  32'(bvalid),  32'h0);
            check("rst_rvalid",  32'(rvalid),  32'h0);
            check("rst_awready", 32'(awready), 32'h0);
            check("rst_arready", 32'(arready), 32'h0);
        end
        @(posedge clk);
        #1;
        areset = 1'b0;
        tick(2);
        check("idle_bvalid", 32'(bvalid), 32'h0);
        check("idle_rvalid", 32'(rvalid), 32'h0);
        rd(A_CTRL,   "rst_ctrl",   32'h0);
        rd(A_GATE,   "rst_gate",   32'h0);
        rd(A_COUNT,  "rst_count",  32'h0);
        rd(A_STATUS, "rst_status", 32'h0);
`ifdef FREQ_CNT_IRQ_EN
        check("rst_irq", 32'(irq), 32'h0);
`endif

        // 2. basic measurement, f_in period 10 cycles over a 100-cycle gate
        f_half = 50;
        tick(30);
        wr(A_GATE, 32'd100);
        rd(A_GATE, "gate_100", 32'd100);
        wr(A_CTRL, 32'h1);
        rd(A_STATUS, "busy_running", 32'h1);
        tick(110);
        rd(A_STATUS, "done_after_gate", 32'h2);
        axi_read(A_COUNT, "count_p10", 32'd10, 32'hFFFF_FFFF, 32'd1, 0);
        rd(A_CTRL, "start_reads_0", 32'h0);

        // 3. independent AW/W, byte strobes, read-only writes
        wr(A_STATUS, 32'hF);
        rd(A_STATUS, "status_w1c_all", 32'h0);
        bc = b_count;
        axi_write(A_GATE, 32'h64, 4'hF, 0, 5);
        check("single_b_aw_first", 32'(b_count - bc), 32'h1);
        rd(A_GATE, "gate_aw_first", 32'h64);
        bc = b_count;
        axi_write(A_GATE, 32'h77, 4'hF, 5, 0);
        check("single_b_w_first", 32'(b_count - bc), 32'h1);
        rd(A_GATE, "gate_w_first", 32'h77);
        wr(A_GATE, 32'h64);
        axi_write(A_GATE, 32'hAABB_CCFF, 4'b0001, 0, 0);
        rd(A_GATE, "gate_strb_byte0", 32'h0000_00FF);
        wr(A_COUNT, 32'hDEAD_BEEF);
        axi_read(A_COUNT, "count_ro", 32'd10, 32'hFFFF_FFFF, 32'd1, 0);

        // 4. zero gate, START while busy, GATE write while busy
        wr(A_GATE, 32'h0);
        wr(A_CTRL, 32'h1);
        rd(A_STATUS, "gerr_set", 32'h8);
        wr(A_STATUS, 32'h8);
        rd(A_STATUS, "gerr_cleared", 32'h0);
        wr(A_GATE, 32'd100);
        wr(A_CTRL, 32'h1);
        tick(30);
        wr(A_CTRL, 32'h1);
        wr(A_GATE, 32'd30);
        tick(70);
        rd(A_STATUS, "no_restart", 32'h2);
        axi_read(A_COUNT, "count_single_gate", 32'd10, 32'hFFFF_FFFF, 32'd1, 0);
        rd(A_GATE, "gate_written_busy", 32'd30);

        // 5. saturation with a 4-bit counter, f_in period 4 cycles
        wr(A_STATUS, 32'hF);
        f_half = 20;
        tick(10);
        wr(A_GATE, 32'd100);
        wr(A_CTRL, 32'h1);
        tick(115);
        rd(A_COUNT, "count_saturated", 32'hF);
        rd(A_STATUS, "ovf_done", 32'h6);
        wr(A_STATUS, 32'h4);
        rd(A_STATUS, "ovf_cleared", 32'h2);
        wr(A_STATUS, 32'h2);
        rd(A_STATUS, "done_cleared", 32'h0);

        // 6. continuous mode, f_in period 5 cycles, 50-cycle gate, held R channel
        f_half = 25;
        tick(10);
        wr(A_GATE, 32'd50);
        wr(A_CTRL, 32'h7);
        axi_read(A_GATE, "gate_rready_low", 32'd50, 32'hFFFF_FFFF, 32'h0, 20);
        rd(A_CTRL, "ctrl_cont", 32'h2 | IE_RB);
        tick(30);
        rd_m(A_STATUS, "cont_done_1", 32'h2, 32'h2);
`ifdef FREQ_CNT_IRQ_EN
        check("irq_on_done", 32'(irq), 32'h1);
`endif
        wr(A_STATUS, 32'h2);
        rd_m(A_STATUS, "cont_done_cleared", 32'h0, 32'h2);
`ifdef FREQ_CNT_IRQ_EN
        check("irq_after_clear", 32'(irq), 32'h0);
`endif
        tick(20);
        rd_m(A_STATUS, "cont_not_yet", 32'h0, 32'h2);
        tick(20);
        rd_m(A_STATUS, "cont_done_2", 32'h2, 32'h2);
        axi_read(A_COUNT, "count_cont", 32'd10, 32'hFFFF_FFFF, 32'd1, 0);
        wr(A_CTRL, IE_RB);
        tick(15);
        rd(A_STATUS, "finishing_gate", 32'h3);
        tick(30);
        rd(A_STATUS, "stopped_after_cont", 32'h2);
        tick(60);
        rd(A_STATUS, "stays_idle", 32'h2);
        wr(A_STATUS, 32'h2);
        tick(2);
`ifdef FREQ_CNT_IRQ_EN
        check("irq_final_clear", 32'(irq), 32'h0);
`endif

        // 7. reset in the middle of a measurement
        wr(A_GATE, 32'd40);
        wr(A_CTRL, 32'h3);
        tick(10);
        areset = 1'b1;
        tick(2);
        areset = 1'b0;
        tick(2);
        rd(A_COUNT,  "rst_mid_count",  32'h0);
        rd(A_STATUS, "rst_mid_status", 32'h0);
        rd(A_GATE,   "rst_mid_gate",   32'h0);
        rd(A_CTRL,   "rst_mid_ctrl",   32'h0);

        tick(5);
        check("sb_empty", 32'(rd_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
